sw_bus_sequencer: RTL and testbench
===================================

Name: sw_bus_sequencer

Overview:
- Turns one raw interactive switch into a stepped WIDTH-bit input code for a downstream module input bus (default 2 bits).
- Synchronises and debounces the switch.
- Each debounced press advances the code by one, modulo 2^WIDTH.
- Every step is delivered over a valid/ready handshake, so a slow consumer never misses a step.
- Sits between a SWITCH source and a multi-bit module input port. It replaces direct 1-bit-to-bus wiring.

Parameters:
- WIDTH, 2: width of the delivered code bus.
- DEB_CYCLES, 4: consecutive stable cycles before a level change is accepted; legal range is >= 2.
- PEND_MAX, 3: maximum undelivered steps held while the consumer stalls; legal range is >= 1.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- sw_raw, input, 1: raw switch level, asynchronous to clk, may bounce.
- a_data, output, WIDTH: code presented to the consumer.
- a_valid, output, 1: a_data holds an undelivered step.
- a_ready, input, 1: consumer accepts a_data this cycle.
- sw_level, output, 1: debounced switch level.
- overflow, output, 1: one-cycle pulse when a press is dropped because pend is full.

Behaviour:
- Reset (rst_n=0 at a clk edge): sync FFs=0, sw_level=0, deb_cnt=0, code=0, a_data=0, a_valid=0, pend=0, overflow=0. This applies mid-debounce and mid-handshake alike; any pending steps are discarded.
- Synchroniser: two flops, sw_raw -> s1 -> sw_sync.
- Debounce FSM, states LO_STABLE, LO_TO_HI, HI_STABLE, HI_TO_LO:
  - A mismatch between sw_sync and sw_level enters the corresponding TO state. The match-to-mismatch edge also clears deb_cnt to 0.
  - Each further mismatch cycle increments deb_cnt.
  - Any match returns to the STABLE state and clears deb_cnt. Bounce therefore restarts the count.
  - On the edge where deb_cnt == DEB_CYCLES-1 and the mismatch persists, sw_level toggles and the FSM enters the opposite STABLE state.
  - A rise of sw_level raises the internal one-cycle event press. A fall produces no event.
- Latency: sw_raw held high from edge 0 -> sw_level=1 after edge DEB_CYCLES+2 -> a_valid=1 after edge DEB_CYCLES+3, when the queue was empty.
- Step queue:
  - code is the latest stepped value.
  - a_data is the oldest undelivered value.
  - pend counts steps not yet presented, beyond a_data.
  - transfer = a_valid && a_ready.
- Per-edge rules, where press is the event from the previous edge:
  - press, a_valid=0: code<=code+1; a_data<=code+1; a_valid<=1.
  - press, a_valid=1, no transfer: if pend<PEND_MAX then pend+1 and code+1; else drop the press, leave code unchanged, overflow<=1.
  - transfer, pend>0, no press: a_data<=a_data+1; pend-1; a_valid stays 1.
  - transfer, pend=0, no press: a_valid<=0.
  - transfer and press together:
    - code<=code+1.
    - If pend=0, then a_data<=code+1 and a_valid stays 1.
    - Else a_data<=a_data+1 and pend unchanged.
    - No overflow in this case.
- Invariant: whenever a_valid=1, a_data + pend == code (mod 2^WIDTH).
- Arithmetic: all increments are WIDTH-bit and wrap (2^WIDTH-1 -> 0).
- a_data is held constant while a_valid=1 and a_ready=0.
- overflow is 0 in every cycle not named above.

Decomposition:
- Package sw_seq_pkg holds:
  - the deb_state_e enum (LO_STABLE, LO_TO_HI, HI_STABLE, HI_TO_LO);
  - the DEB_CNT_W and PEND_W width helper functions (clog2-based).
- Sub-module sw_debounce holds the synchroniser, the debounce FSM and deb_cnt. Its outputs are sw_level and press.
- The top level holds the step queue and the handshake.

Test Plan:
- Reset then single press:
  - Stimulus: rst_n low 3 cycles; sw_raw=1 from edge 0; a_ready=1.
  - Required: a_valid=1 with a_data=1 after edge 7 (DEB_CYCLES=4); a_valid=0 the next cycle; overflow never asserted.
- Bounce rejection:
  - Stimulus: sw_raw toggles 1,0,1,0 on successive edges, then holds 0.
  - Required: sw_level stays 0; a_valid never rises.
- Wrap-around:
  - Stimulus: 4 clean presses (sw_raw high 8 cycles, low 8 cycles each); a_ready=1.
  - Required: delivered a_data sequence is 1,2,3,0.
- Stall and overflow:
  - Stimulus: a_ready=0; 5 clean presses.
  - Required: a_data=1 held; pend reaches 3; overflow pulses once on the 5th press.
  - Then: a_ready=1 delivers 2,3,0 on consecutive cycles, then a_valid=0.
- Simultaneous:
  - Stimulus: a_valid=1, a_data=1, pend=0; press and transfer on the same edge.
  - Required: next a_data=2; a_valid=1; pend=0.
- Reset mid-operation:
  - Stimulus: rst_n=0 while pend=2 and deb FSM is in LO_TO_HI.
  - Required: next cycle all outputs are 0 and the FSM is in LO_STABLE.

Source files
------------

// File: rtl/sw_seq_pkg.sv
// Shared types and width helpers for the switch-to-bus sequencer.
package sw_seq_pkg;

  // Debounce FSM states: a STABLE state per level, a TO state while a change is being qualified.
  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    LO_TO_HI  = 2'd1,
    HI_STABLE = 2'd2,
    HI_TO_LO  = 2'd3
  } deb_state_e;

  // Width of the debounce counter; it must hold 0 .. deb_cycles-1.
  function automatic int DEB_CNT_W(input int deb_cycles);
    return (deb_cycles <= 2) ? 1 : $clog2(deb_cycles);
  endfunction

  // Width of the pending-step counter; it must hold 0 .. pend_max.
  function automatic int PEND_W(input int pend_max);
    return (pend_max <= 1) ? 1 : $clog2(pend_max + 1);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus debounce FSM; emits the debounced level and a
// one-cycle press event on each accepted rising level change.
module sw_debounce
  import sw_seq_pkg::*;
#(
  parameter int  DEB_CYCLES = 4,
  localparam int CW         = DEB_CNT_W(DEB_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_raw,
  output logic       sw_level,
  output logic       press,
  output deb_state_e state_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q, sync_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // State register: synchroniser, FSM state, counter and press event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= LO_STABLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= sw_raw;
      sync_q  <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Next state: a mismatch must persist DEB_CYCLES more edges; any match restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      LO_STABLE: begin
        if (sync_q) begin
          state_d = LO_TO_HI;
          cnt_d   = '0;
        end
      end
      LO_TO_HI: begin
        if (!sync_q) begin
          state_d = LO_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HI_STABLE;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HI_STABLE: begin
        if (!sync_q) begin
          state_d = HI_TO_LO;
          cnt_d   = '0;
        end
      end
      HI_TO_LO: begin
        if (sync_q) begin
          state_d = HI_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LO_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = LO_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: the debounced level is encoded in the state itself.
  always_comb begin
    sw_level = (state_q == HI_STABLE) || (state_q == HI_TO_LO);
    press    = press_q;
    state_o  = state_q;
  end

endmodule

// File: rtl/sw_bus_sequencer.sv
// Stepped WIDTH-bit code generator driven by a debounced switch. Each press
// advances the code; steps queue up (up to PEND_MAX beyond a_data) while the
// consumer stalls.
// Handshake: a_data is a step offered while a_valid=1; it is consumed on an
// edge where a_valid && a_ready, and a_data stays constant until then.
module sw_bus_sequencer
  import sw_seq_pkg::*;
#(
  parameter int  WIDTH      = 2,
  parameter int  DEB_CYCLES = 4,
  parameter int  PEND_MAX   = 3,
  localparam int PW         = PEND_W(PEND_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_raw,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic             sw_level,
  output logic             overflow,
  output deb_state_e       dbg_state,
  output logic [PW-1:0]    dbg_pend
);

  localparam logic [PW-1:0] PEND_LIMIT = PW'(PEND_MAX);

  logic             press;
  logic             transfer;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic             ovf_q, ovf_d;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .sw_level (sw_level),
    .press    (press),
    .state_o  (dbg_state)
  );

  assign transfer = valid_q && a_ready;

  // Queue registers; reset discards every pending step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Step queue update; pending values are implicit since a_data + pend == code.
  always_comb begin
    code_d  = code_q;
    data_d  = data_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    if (press) begin
      if (!valid_q) begin
        code_d  = code_q + WIDTH'(1);
        data_d  = code_q + WIDTH'(1);
        valid_d = 1'b1;
      end else if (transfer) begin
        code_d = code_q + WIDTH'(1);
        if (pend_q == '0) data_d = code_q + WIDTH'(1);
        else              data_d = data_q + WIDTH'(1);
      end else if (pend_q < PEND_LIMIT) begin
        pend_d = pend_q + PW'(1);
        code_d = code_q + WIDTH'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (transfer) begin
      if (pend_q != '0) begin
        data_d = data_q + WIDTH'(1);
        pend_d = pend_q - PW'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Output mapping.
  always_comb begin
    a_data   = data_q;
    a_valid  = valid_q;
    overflow = ovf_q;
    dbg_pend = pend_q;
  end

endmodule

// File: tb/tb_sw_bus_sequencer.sv
// Bench for sw_bus_sequencer: directed scenarios plus random switch/ready
// traffic, all compared against a queue-based reference model.
module tb_sw_bus_sequencer;
  import sw_seq_pkg::*;

  localparam int WIDTH      = 2;
  localparam int DEB_CYCLES = 4;
  localparam int PEND_MAX   = 3;
  localparam int PW         = PEND_W(PEND_MAX);

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sw_raw = 1'b0;
  logic             a_ready = 1'b0;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             sw_level;
  logic             overflow;
  deb_state_e       dbg_state;
  logic [PW-1:0]    dbg_pend;

  always #5 clk = ~clk;

  sw_bus_sequencer #(.WIDTH(WIDTH), .DEB_CYCLES(DEB_CYCLES), .PEND_MAX(PEND_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .sw_level  (sw_level),
    .overflow  (overflow),
    .dbg_state (dbg_state),
    .dbg_pend  (dbg_pend)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_ovf    = 0;

  logic [WIDTH-1:0] exp_q[$];     // undelivered steps, oldest first
  logic [WIDTH-1:0] delivered[$]; // values seen crossing the handshake
  logic [WIDTH-1:0] m_code = '0;
  bit               m_r1 = 0, m_sync = 0, m_level = 0, m_press = 0, m_ovf = 0;
  int               m_run = 0;    // consecutive edges where synced input != level

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference model, evaluated with pre-edge state.
  task automatic model_edge(input bit raw, input bit ready, input bit rstn);
    bit old_press;
    bit xfer;
    if (!rstn) begin
      m_r1 = 0; m_sync = 0; m_level = 0; m_press = 0; m_ovf = 0; m_run = 0;
      m_code = '0;
      exp_q.delete();
    end else begin
      old_press = m_press;
      xfer      = (exp_q.size() > 0) && ready;
      if (m_sync != m_level) begin
        m_run++;
        if (m_run == DEB_CYCLES + 1) begin
          m_level = !m_level;
          m_run   = 0;
          m_press = m_level;
        end else begin
          m_press = 0;
        end
      end else begin
        m_run   = 0;
        m_press = 0;
      end
      m_sync = m_r1;
      m_r1   = raw;
      m_ovf  = 0;
      if (xfer) void'(exp_q.pop_front());
      if (old_press) begin
        if (exp_q.size() < PEND_MAX + 1) begin
          m_code = m_code + 1'b1;
          exp_q.push_back(m_code);
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_val("a_valid", 32'(a_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check_val("a_data", 32'(a_data), 32'(exp_q[0]));
    check_val("pend", 32'(dbg_pend), (exp_q.size() > 0) ? 32'(exp_q.size() - 1) : 32'd0);
    check_val("sw_level", 32'(sw_level), 32'(m_level));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit raw, input bit ready, input bit rstn);
    sw_raw  = raw;
    a_ready = ready;
    rst_n   = rstn;
    if (rstn && a_valid && ready) delivered.push_back(a_data);
    @(posedge clk);
    model_edge(raw, ready, rstn);
    #1;
    compare_all();
    if (overflow) n_ovf++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_clean(input bit ready);
    for (int i = 0; i < 8; i++) cycle(1'b1, ready, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [WIDTH-1:0] wrap_exp[4];
    int  seen_level;
    int  seen_valid;
    int  raw_hold;
    bit  raw_lvl;

    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0;

    // Reset then single press
    do_reset(3);
    check_val("rst_a_data", 32'(a_data), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(LO_STABLE));
    n_ovf = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      if (i == DEB_CYCLES + 1) check_val("lat_level_pre", 32'(sw_level), 32'd0);
      if (i == DEB_CYCLES + 2) check_val("lat_level", 32'(sw_level), 32'd1);
      if (i == DEB_CYCLES + 2) check_val("lat_valid_pre", 32'(a_valid), 32'd0);
      if (i == DEB_CYCLES + 3) begin
        check_val("lat_valid", 32'(a_valid), 32'd1);
        check_val("lat_data", 32'(a_data), 32'd1);
      end
      if (i == DEB_CYCLES + 4) check_val("lat_valid_drop", 32'(a_valid), 32'd0);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1);
    check_val("single_no_ovf", 32'(n_ovf), 32'd0);

    // Bounce rejection
    seen_level = 0;
    seen_valid = 0;
    for (int i = 0; i < 16; i++) begin
      cycle((i < 4) ? ((i % 2) == 0) : 1'b0, 1'b1, 1'b1);
      if (sw_level) seen_level++;
      if (a_valid) seen_valid++;
    end
    check_val("bounce_level", 32'(seen_level), 32'd0);
    check_val("bounce_valid", 32'(seen_valid), 32'd0);

    // Wrap-around
    do_reset(2);
    delivered.delete();
    for (int p = 0; p < 4; p++) press_clean(1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1);
    check_val("wrap_count", 32'(delivered.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < delivered.size()) check_val("wrap_seq", 32'(delivered[i]), 32'(wrap_exp[i]));

    // Stall and overflow
    do_reset(2);
    n_ovf = 0;
    for (int p = 0; p < 5; p++) press_clean(1'b0);
    check_val("stall_data", 32'(a_data), 32'd1);
    check_val("stall_pend", 32'(dbg_pend), 32'd3);
    check_val("stall_ovf_count", 32'(n_ovf), 32'd1);
    cycle(1'b0, 1'b1, 1'b1);
    check_val("drain_0", 32'(a_data), 32'd2);
    cycle(1'b0, 1'b1, 1'b1);
    check_val("drain_1", 32'(a_data), 32'd3);
    cycle(1'b0, 1'b1, 1'b1);
    check_val("drain_2", 32'(a_data), 32'd0);
    cycle(1'b0, 1'b1, 1'b1);
    check_val("drain_done", 32'(a_valid), 32'd0);

    // Simultaneous press and transfer
    do_reset(2);
    press_clean(1'b0);
    check_val("simul_setup", 32'(a_data), 32'd1);
    for (int k = 0; k < 20 && !m_press; k++) cycle(1'b1, 1'b0, 1'b1);
    if (!m_press) check_val("simul_press_timeout", 32'd0, 32'd1);
    cycle(1'b1, 1'b1, 1'b1);
    check_val("simul_data", 32'(a_data), 32'd2);
    check_val("simul_valid", 32'(a_valid), 32'd1);
    check_val("simul_pend", 32'(dbg_pend), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1);

    // Reset mid-operation
    do_reset(2);
    for (int p = 0; p < 3; p++) press_clean(1'b0);
    check_val("mid_pend", 32'(dbg_pend), 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    check_val("mid_state", 32'(dbg_state), 32'(LO_TO_HI));
    cycle(1'b1, 1'b0, 1'b0);
    check_val("mid_rst_valid", 32'(a_valid), 32'd0);
    check_val("mid_rst_data", 32'(a_data), 32'd0);
    check_val("mid_rst_pend", 32'(dbg_pend), 32'd0);
    check_val("mid_rst_level", 32'(sw_level), 32'd0);
    check_val("mid_rst_ovf", 32'(overflow), 32'd0);
    check_val("mid_rst_state", 32'(dbg_state), 32'(LO_STABLE));

    // Random traffic: bouncy and clean switch runs, bursty ready, rare resets
    do_reset(2);
    raw_lvl  = 1'b0;
    raw_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (raw_hold == 0) begin
        raw_lvl  = !raw_lvl;
        raw_hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(6, 14);
      end
      raw_hold--;
      cycle(raw_lvl, ($urandom_range(0, 9) < 4), ($urandom_range(0, 399) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
